// File: rtl/rptr_handler.sv
// Read-side pointer and flag generator for the dual-clock FIFO (rclk domain).
// Optional sticky underflow status is built when RPTR_UNDERFLOW_EN is defined.
module rptr_handler #(
    parameter int PTR_WIDTH        = 3,
    parameter int ALMOST_EMPTY_LVL = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH-1:0] g_wptr_sync,
    output logic [PTR_WIDTH-1:0] b_rptr,
    output logic [PTR_WIDTH-1:0] g_rptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH-1:0] rd_level,
    input  logic                 clr_err,
    output logic                 underflow,
    output logic [7:0]           underflow_cnt
);

    localparam logic [PTR_WIDTH-1:0] AE_LVL = PTR_WIDTH'(ALMOST_EMPTY_LVL);

    logic                 accepted;
    logic [PTR_WIDTH-1:0] b_rptr_next;
    logic [PTR_WIDTH-1:0] g_rptr_next;
    logic [PTR_WIDTH-1:0] b_wptr_sync;
    logic [PTR_WIDTH-1:0] level_next;

    assign accepted    = r_en & ~empty;
    assign b_rptr_next = b_rptr + {{(PTR_WIDTH-1){1'b0}}, accepted};
    assign g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;

    always_comb begin
        b_wptr_sync = '0;
        b_wptr_sync[PTR_WIDTH-1] = g_wptr_sync[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b_wptr_sync[i] = b_wptr_sync[i+1] ^ g_wptr_sync[i];
        end
    end

    // Level uses the post-read pointer so reads lower it on the consuming edge.
    assign level_next = b_wptr_sync - b_rptr_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == g_wptr_sync);
            almost_empty <= (level_next <= AE_LVL);
            rd_level     <= level_next;
        end
    end

`ifdef RPTR_UNDERFLOW_EN
    logic       uf_q;
    logic [7:0] uf_cnt_q;

    // clr_err wins over a simultaneous underflow event, which is dropped.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (clr_err) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (r_en & empty) begin
            uf_q <= 1'b1;
            if (uf_cnt_q != 8'hff) begin
                uf_cnt_q <= uf_cnt_q + 8'd1;
            end
        end
    end

    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign underflow      = 1'b0;
    assign underflow_cnt  = '0;
`endif

endmodule

// File: tb/tb_rptr_handler.sv
// Directed self-checking bench for rptr_handler (PTR_WIDTH=4, ALMOST_EMPTY_LVL=2).
`timescale 1ns/1ps
module tb_rptr_handler;

    localparam int W = 4;
`ifdef RPTR_UNDERFLOW_EN
    localparam bit UF = 1'b1;
`else
    localparam bit UF = 1'b0;
`endif

    logic         rclk = 1'b0;
    logic         rrst;
    logic         r_en;
    logic [W-1:0] g_wptr_sync;
    logic [W-1:0] b_rptr;
    logic [W-1:0] g_rptr;
    logic         empty;
    logic         almost_empty;
    logic [W-1:0] rd_level;
    logic         clr_err;
    logic         underflow;
    logic [7:0]   underflow_cnt;

    int checks = 0;
    int errors = 0;

    rptr_handler #(.PTR_WIDTH(W), .ALMOST_EMPTY_LVL(2)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .r_en          (r_en),
        .g_wptr_sync   (g_wptr_sync),
        .b_rptr        (b_rptr),
        .g_rptr        (g_rptr),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .clr_err       (clr_err),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk_ptr(input string tag, input logic [W-1:0] b, input logic [W-1:0] g,
                           input logic [W-1:0] lvl, input logic e, input logic ae);
        chk({tag, "_b_rptr"}, 32'(b_rptr), 32'(b));
        chk({tag, "_g_rptr"}, 32'(g_rptr), 32'(g));
        chk({tag, "_rd_level"}, 32'(rd_level), 32'(lvl));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_almost_empty"}, 32'(almost_empty), 32'(ae));
    endtask

    initial begin
        rrst = 1'b1; r_en = 1'b0; clr_err = 1'b0; g_wptr_sync = '0;
        #2;
        chk_ptr("reset", 4'd0, 4'b0000, 4'd0, 1'b1, 1'b1);
        chk("reset_uf", 32'(underflow), 32'(0));
        chk("reset_uf_cnt", 32'(underflow_cnt), 32'(0));
        @(negedge rclk);
        rrst = 1'b0;
        step();
        chk_ptr("idle", 4'd0, 4'b0000, 4'd0, 1'b1, 1'b1);

        // fill visible: writer at 3
        g_wptr_sync = 4'b0010;
        step();
        chk_ptr("fill", 4'd0, 4'b0000, 4'd3, 1'b0, 1'b0);

        // drain three words
        r_en = 1'b1;
        step(); chk_ptr("drain1", 4'd1, 4'b0001, 4'd2, 1'b0, 1'b1);
        step(); chk_ptr("drain2", 4'd2, 4'b0011, 4'd1, 1'b0, 1'b1);
        step(); chk_ptr("drain3", 4'd3, 4'b0010, 4'd0, 1'b1, 1'b1);

        // reads while empty are ignored (underflow events)
        step(); step(); step();
        chk_ptr("uf_hold", 4'd3, 4'b0010, 4'd0, 1'b1, 1'b1);
        chk("uf_flag", 32'(underflow), 32'(UF ? 1 : 0));
        chk("uf_cnt3", 32'(underflow_cnt), 32'(UF ? 3 : 0));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0; r_en = 1'b0;
        chk("uf_clr_flag", 32'(underflow), 32'(0));
        chk("uf_clr_cnt", 32'(underflow_cnt), 32'(0));
        chk("uf_clr_b_rptr", 32'(b_rptr), 32'(3));

        // full-depth level: writer at 11, reader at 3
        g_wptr_sync = 4'b1110;
        step();
        chk_ptr("full", 4'd3, 4'b0010, 4'd8, 1'b0, 1'b0);
        r_en = 1'b1;
        repeat (8) step();
        r_en = 1'b0;
        chk_ptr("read8", 4'd11, 4'b1110, 4'd0, 1'b1, 1'b1);

        // writer at 15, reader drains to 15
        g_wptr_sync = 4'b1000;
        step();
        chk_ptr("w15", 4'd11, 4'b1110, 4'd4, 1'b0, 1'b0);
        r_en = 1'b1;
        repeat (4) step();
        r_en = 1'b0;
        chk_ptr("r15", 4'd15, 4'b1000, 4'd0, 1'b1, 1'b1);

        // wrap: writer at 1 (17 mod 16), level 2
        g_wptr_sync = 4'b0001;
        step();
        chk_ptr("wrap_pre", 4'd15, 4'b1000, 4'd2, 1'b0, 1'b1);
        r_en = 1'b1;
        step(); chk_ptr("wrap1", 4'd0, 4'b0000, 4'd1, 1'b0, 1'b1);
        step(); chk_ptr("wrap2", 4'd1, 4'b0001, 4'd0, 1'b1, 1'b1);
        step(); chk_ptr("wrap3", 4'd1, 4'b0001, 4'd0, 1'b1, 1'b1);
        r_en = 1'b0;
        chk("wrap_uf_cnt", 32'(underflow_cnt), 32'(UF ? 1 : 0));

        // reach b_rptr=5 with data outstanding, then async reset between edges
        g_wptr_sync = 4'b0100;
        step();
        chk_ptr("w7", 4'd1, 4'b0001, 4'd6, 1'b0, 1'b0);
        r_en = 1'b1;
        repeat (4) step();
        r_en = 1'b0;
        chk_ptr("r5", 4'd5, 4'b0111, 4'd2, 1'b0, 1'b1);
        #2;
        rrst = 1'b1;
        #1;
        chk_ptr("arst", 4'd0, 4'b0000, 4'd0, 1'b1, 1'b1);
        chk("arst_uf", 32'(underflow), 32'(0));
        chk("arst_uf_cnt", 32'(underflow_cnt), 32'(0));
        @(negedge rclk);
        rrst = 1'b0;
        step();
        chk_ptr("post_rst", 4'd0, 4'b0000, 4'd7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
